// File: rtl/wishbone_timer_pkg.sv
// rtl/wishbone_timer_pkg.sv - register map, bit positions and bus FSM states for wishbone_timer
// Shared by the timer top and its testbench; holds no logic.
package wishbone_timer_pkg;

  // Register offsets, decoded from dir_i[2:0]
  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_PRESC     = 3'd1;
  localparam logic [2:0] REG_RELOAD_LO = 3'd2;
  localparam logic [2:0] REG_RELOAD_HI = 3'd3;
  localparam logic [2:0] REG_COUNT_LO  = 3'd4;
  localparam logic [2:0] REG_COUNT_HI  = 3'd5;
  localparam logic [2:0] REG_STATUS    = 3'd6;
  localparam logic [2:0] REG_RSVD      = 3'd7;

  // CTRL bit positions
  localparam int CTRL_EN    = 0;
  localparam int CTRL_AUTO  = 1;
  localparam int CTRL_IRQEN = 2;

  // STATUS bit positions
  localparam int STATUS_EXP = 0;

  // Slave handshake: one access per IDLE->ACK pass, so a held strobe
  // is acknowledged every other cycle.
  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_ACK  = 1'b1
  } bus_state_t;

endpackage

// File: rtl/wishbone_timer_if.sv
// rtl/wishbone_timer_if.sv - shared Wishbone bus signals seen by the timer slave
// Signals: dir_i (address), we_i, stb_i, cyc_i, dat_i (master -> slave);
//          dat_o, ack_o (slave -> master, tri-stated by each slave on the shared bus).
interface wishbone_timer_if;
  logic [15:0] dir_i;
  logic        we_i;
  logic        stb_i;
  logic        cyc_i;
  logic [7:0]  dat_i;
  wire  [7:0]  dat_o;
  wire         ack_o;

  modport master (
    output dir_i, we_i, stb_i, cyc_i, dat_i,
    input  dat_o, ack_o
  );

  modport slave (
    input  dir_i, we_i, stb_i, cyc_i, dat_i,
    output dat_o, ack_o
  );
endinterface

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - clock prescaler producing one tick every presc+1 enabled clocks
// Ports: clk, reset (async active-low), enable (count only when 1),
//        clear (restart from 0, wins over enable), presc[7:0], tick (one-cycle pulse).
module timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       clear,
  input  logic [7:0] presc,
  output logic       tick
);

  logic [7:0] cnt_q;

  // Tick is decoded from the counter so the first one lands presc+1
  // clocks after a clear.
  assign tick = enable && (cnt_q == presc);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 8'd0;
    end else if (clear) begin
      cnt_q <= 8'd0;
    end else if (enable) begin
      cnt_q <= tick ? 8'd0 : cnt_q + 8'd1;
    end
  end

endmodule

// File: rtl/wishbone_timer.sv
// rtl/wishbone_timer.sv - 16-bit down-counting Wishbone timer slave with sticky expiry flag and IRQ
// Ports: clk, reset (async active-low), bus (wishbone_timer_if.slave), irq_o (EXP & IRQEN).
// Parameter SEL: value of dir_i[15:12] that selects this slave.
// Optional WB_TIMER_LATCH_EN: a COUNT_LO read latches COUNT[15:8] for the next COUNT_HI read.
module wishbone_timer
  import wishbone_timer_pkg::*;
#(
  parameter logic [3:0] SEL = 4'b0011
) (
  input  logic                   clk,
  input  logic                   reset,
  wishbone_timer_if.slave        bus,
  output logic                   irq_o
);

  bus_state_t  state_q, state_d;
  logic        selected, access, wr, rd, rd_q;
  logic [2:0]  off;
  logic [7:0]  dat_q, rdata;

  logic        en_q, auto_q, irqen_q, exp_q;
  logic [7:0]  presc_q;
  logic [15:0] reload_q, count_q;

  logic        ctrl_wr, start, stop_wr, presc_wr, tick, tick_eff;
  logic        unused_dir;

`ifdef WB_TIMER_LATCH_EN
  logic [7:0]  shadow_q;
`endif

  assign off        = bus.dir_i[2:0];
  assign unused_dir = ^bus.dir_i[11:3];
  assign selected   = bus.cyc_i & bus.stb_i & (bus.dir_i[15:12] == SEL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= BUS_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = BUS_IDLE;
    access  = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        if (selected) begin
          state_d = BUS_ACK;
          access  = 1'b1;
        end
      end
      default: state_d = BUS_IDLE;
    endcase
  end

  assign wr = access & bus.we_i;
  assign rd = access & ~bus.we_i;

  // Shared bus: drive only while this slave is addressed.
  assign bus.ack_o = selected ? (state_q == BUS_ACK) : 1'bz;
  assign bus.dat_o = (selected && (state_q == BUS_ACK) && rd_q) ? dat_q : 8'hzz;

  assign ctrl_wr  = wr && (off == REG_CTRL);
  assign start    = ctrl_wr && bus.dat_i[CTRL_EN] && !en_q;
  assign stop_wr  = ctrl_wr && !bus.dat_i[CTRL_EN];
  assign presc_wr = wr && (off == REG_PRESC);
  // Disabling the timer in a tick cycle discards that tick.
  assign tick_eff = tick && !stop_wr;

  timer_prescaler u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .enable (en_q),
    .clear  (start | presc_wr),
    .presc  (presc_q),
    .tick   (tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q     <= 1'b0;
      auto_q   <= 1'b0;
      irqen_q  <= 1'b0;
      exp_q    <= 1'b0;
      presc_q  <= 8'd0;
      reload_q <= 16'd0;
      count_q  <= 16'd0;
    end else begin
      if (wr) begin
        case (off)
          REG_CTRL: begin
            en_q    <= bus.dat_i[CTRL_EN];
            auto_q  <= bus.dat_i[CTRL_AUTO];
            irqen_q <= bus.dat_i[CTRL_IRQEN];
            if (start) count_q <= reload_q;
          end
          REG_PRESC:     presc_q         <= bus.dat_i;
          REG_RELOAD_LO: reload_q[7:0]   <= bus.dat_i;
          REG_RELOAD_HI: reload_q[15:8]  <= bus.dat_i;
          REG_STATUS:    if (bus.dat_i[STATUS_EXP]) exp_q <= 1'b0;
          default: ;
        endcase
      end
      // Tick handling comes after the bus write so an expiry beats a
      // same-cycle STATUS clear.
      if (tick_eff) begin
        if (count_q != 16'd0) begin
          count_q <= count_q - 16'd1;
        end else begin
          exp_q <= 1'b1;
          if (auto_q) count_q <= reload_q;
          else        en_q    <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    rdata = 8'd0;
    case (off)
      REG_CTRL:      rdata = {5'd0, irqen_q, auto_q, en_q};
      REG_PRESC:     rdata = presc_q;
      REG_RELOAD_LO: rdata = reload_q[7:0];
      REG_RELOAD_HI: rdata = reload_q[15:8];
      REG_COUNT_LO:  rdata = count_q[7:0];
`ifdef WB_TIMER_LATCH_EN
      REG_COUNT_HI:  rdata = shadow_q;
`else
      REG_COUNT_HI:  rdata = count_q[15:8];
`endif
      REG_STATUS:    rdata = {7'd0, exp_q};
      REG_RSVD:      rdata = 8'd0;
      default:       rdata = 8'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q  <= 1'b0;
      dat_q <= 8'd0;
    end else begin
      rd_q <= rd;
      if (rd) dat_q <= rdata;
    end
  end

`ifdef WB_TIMER_LATCH_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          shadow_q <= 8'd0;
    else if (rd && off == REG_COUNT_LO)  shadow_q <= count_q[15:8];
  end
`endif

  assign irq_o = exp_q & irqen_q;

endmodule

// File: tb/tb_wishbone_timer.sv
// tb/tb_wishbone_timer.sv - self-checking bench for wishbone_timer with a read-data scoreboard
module tb_wishbone_timer;
  import wishbone_timer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        irq_o;
  int unsigned cyc_cnt = 0;
  int          n_vec = 0;
  int          n_miss = 0;
  int unsigned last_ack = 0;
  int unsigned last_lat = 0;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;
  exp_t sb_q[$];

`ifdef WB_TIMER_LATCH_EN
  localparam logic [7:0] HI_AFTER = 8'h01;
`else
  localparam logic [7:0] HI_AFTER = 8'h00;
`endif

  localparam logic [15:0] BASE = 16'h3000;

  wishbone_timer_if bus ();

  wishbone_timer #(.SEL(4'h3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .irq_o (irq_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bus_cycle(input logic [15:0] a, input logic w, input logic [7:0] d,
                           input int unsigned at_cyc, output logic [7:0] rdat);
    int unsigned start;
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    while (cyc_cnt + 1 < at_cyc) @(negedge clk);
    start = cyc_cnt;
    bus.dir_i = a;
    bus.we_i  = w;
    bus.dat_i = d;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus.ack_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    rdat     = bus.dat_o;
    last_ack = cyc_cnt;
    last_lat = cyc_cnt - start;
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    bus.we_i  = 1'b0;
    if (!seen) check_val("ack_timeout", 32'(seen), 32'd1);
  endtask

  task automatic wb_write(input logic [2:0] r, input logic [7:0] d, input int unsigned at_cyc = 0);
    logic [7:0] rd_unused;
    bus_cycle(BASE | {13'd0, r}, 1'b1, d, at_cyc, rd_unused);
  endtask

  task automatic wb_read_addr(input logic [15:0] a, input logic [7:0] exp, input string tag);
    logic [7:0] rdat;
    exp_t e;
    sb_q.push_back('{tag: tag, val: exp});
    bus_cycle(a, 1'b0, 8'd0, 0, rdat);
    e = sb_q.pop_front();
    check_val(e.tag, 32'(rdat), 32'(e.val));
  endtask

  task automatic wb_read(input logic [2:0] r, input logic [7:0] exp, input string tag);
    wb_read_addr(BASE | {13'd0, r}, exp, tag);
  endtask

  task automatic wait_irq_rise(input string tag, output int unsigned rise_cyc);
    bit seen;
    seen = 1'b0;
    rise_cyc = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (irq_o === 1'b1) begin
        seen = 1'b1;
        rise_cyc = cyc_cnt;
        break;
      end
    end
    if (!seen) check_val(tag, 32'(seen), 32'd1);
  endtask

  task automatic probe_unsel(input logic [15:0] a);
    bit acked, drove;
    acked = 1'b0;
    drove = 1'b0;
    @(negedge clk);
    bus.dir_i = a;
    bus.we_i  = 1'b0;
    bus.cyc_i = 1'b1;
    bus.stb_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (bus.ack_o === 1'b1) acked = 1'b1;
      if (bus.dat_o !== 8'hzz && bus.dat_o !== 8'h00) drove = 1'b1;
    end
    bus.cyc_i = 1'b0;
    bus.stb_i = 1'b0;
    check_val("unsel_ack", 32'(acked), 32'd0);
    check_val("unsel_dat", 32'(drove), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned c0, c1, c2;
    reset     = 1'b0;
    bus.dir_i = 16'd0;
    bus.we_i  = 1'b0;
    bus.stb_i = 1'b0;
    bus.cyc_i = 1'b0;
    bus.dat_i = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_irq", 32'(irq_o), 32'd0);
    check_val("rst_ack", 32'(bus.ack_o === 1'b1), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    wb_read(REG_CTRL,      8'h00, "rst_ctrl");
    wb_read(REG_PRESC,     8'h00, "rst_presc");
    wb_read(REG_RELOAD_LO, 8'h00, "rst_reload_lo");
    wb_read(REG_COUNT_LO,  8'h00, "rst_count_lo");
    wb_read(REG_STATUS,    8'h00, "rst_status");

    // Periodic: (4+1)*(3+1) = 20 clocks
    wb_write(REG_PRESC, 8'd3);
    wb_write(REG_RELOAD_LO, 8'd4);
    wb_write(REG_RELOAD_HI, 8'd0);
    wb_write(REG_CTRL, 8'h07);
    c0 = last_ack;
    wb_read(REG_CTRL, 8'h07, "per_ctrl");
    wait_irq_rise("per_rise1_timeout", c1);
    check_val("per_first_period", c1 - c0, 32'd20);
    wb_write(REG_STATUS, 8'h01);
    check_val("per_irq_cleared", 32'(irq_o), 32'd0);
    wait_irq_rise("per_rise2_timeout", c2);
    check_val("per_second_period", c2 - c1, 32'd20);

    // Collision: expiry tick and STATUS clear on the same edge
    wb_write(REG_CTRL, 8'h00);
    wb_write(REG_STATUS, 8'h01);
    wb_write(REG_PRESC, 8'd0);
    wb_write(REG_RELOAD_LO, 8'd9);
    wb_write(REG_CTRL, 8'h07);
    c0 = last_ack;
    wait_irq_rise("col_rise_timeout", c1);
    check_val("col_period", c1 - c0, 32'd10);
    wb_write(REG_STATUS, 8'h01);
    wb_read(REG_STATUS, 8'h00, "col_status_cleared");
    wb_write(REG_STATUS, 8'h01, c0 + 20);
    check_val("col_ack_edge", last_ack - c0, 32'd20);
    wb_read(REG_STATUS, 8'h01, "col_exp_wins");

    // One-shot: RELOAD=2, PRESC=0 -> expiry 3 clocks after start
    wb_write(REG_CTRL, 8'h00);
    wb_write(REG_STATUS, 8'h01);
    wb_write(REG_RELOAD_LO, 8'd2);
    wb_write(REG_PRESC, 8'd0);
    wb_write(REG_CTRL, 8'h05);
    c0 = last_ack;
    wait_irq_rise("os_rise_timeout", c1);
    check_val("os_delay", c1 - c0, 32'd3);
    repeat (10) @(posedge clk);
    wb_read(REG_CTRL,     8'h04, "os_ctrl");
    wb_read(REG_COUNT_LO, 8'h00, "os_count_lo");
    wb_read(REG_COUNT_HI, 8'h00, "os_count_hi");
    wb_write(REG_STATUS, 8'h00);
    wb_read(REG_STATUS,   8'h01, "os_status_w0");

    // Address decode
    probe_unsel(16'h0006);
    wb_read_addr(16'h3FFE, 8'h01, "alias_status");
    check_val("alias_latency", last_lat, 32'd1);

    // Reset mid-count
    wb_write(REG_RELOAD_LO, 8'h00);
    wb_write(REG_RELOAD_HI, 8'h10);
    wb_write(REG_CTRL, 8'h07);
    check_val("pre_reset_irq", 32'(irq_o), 32'd1);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_val("in_reset_irq", 32'(irq_o), 32'd0);
    #4;
    reset = 1'b1;
    wb_read(REG_COUNT_LO, 8'h00, "post_rst_count_lo");
    wb_read(REG_COUNT_HI, 8'h00, "post_rst_count_hi");
    wb_read(REG_CTRL,     8'h00, "post_rst_ctrl");
    repeat (20) @(posedge clk);
    #1;
    check_val("post_rst_irq", 32'(irq_o), 32'd0);
    wb_read(REG_STATUS,   8'h00, "post_rst_status");

    // Read-only and reserved registers, then COUNT_HI coherence
    wb_write(REG_COUNT_LO, 8'h55);
    wb_write(REG_RSVD, 8'hAA);
    wb_read(REG_COUNT_LO, 8'h00, "count_ro");
    wb_read(REG_RSVD,     8'h00, "rsvd_zero");
    wb_write(REG_PRESC, 8'd15);
    wb_write(REG_RELOAD_LO, 8'h00);
    wb_write(REG_RELOAD_HI, 8'h01);
    wb_write(REG_CTRL, 8'h01);
    c0 = last_ack;
    wb_read(REG_COUNT_LO, 8'h00, "latch_lo");
    while (cyc_cnt < c0 + 18) @(posedge clk);
    wb_read(REG_COUNT_HI, HI_AFTER, "latch_hi");
    wb_read(REG_COUNT_LO, 8'hFF, "latch_lo_after_dec");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/wishbone_timer.md
# wishbone_timer

Programmable 16-bit down-counting timer that sits on the shared Wishbone bus as a slave next to the memory slaves and drives one CPU interrupt line. The CPU programs it through the Wishbone master with ordinary memory reads/writes in its own 4 KiB address window. On expiry it raises a sticky status flag and, if enabled, `irq_o`, which feeds one bit of the CPU's 3-bit interrupt input.

## Interface
- `SEL`, default `4'b0011`: decoded value of `dir_i[15:12]` that selects this slave; must differ from every other slave on the bus.
- `clk` in, 1 bit: system clock (the syscon clock); all logic on the rising edge.
- `reset` in, 1 bit: asynchronous, active-low reset.
- `dir_i` in, 16 bits: Wishbone address; `[15:12]` slave select, `[2:0]` register offset, `[11:3]` ignored (aliases).
- `we_i` in, 1 bit: 1 write, 0 read.
- `stb_i` in, 1 bit: strobe.
- `cyc_i` in, 1 bit: bus cycle.
- `dat_i` in, 8 bits: write data from the master.
- `dat_o` out, 8 bits: read data; high-impedance unless acknowledging a read (shared bus).
- `ack_o` out, 1 bit: acknowledge; high-impedance unless selected (shared bus), 0 when selected and idle.
- `irq_o` out, 1 bit: interrupt request, level, active-high.

## Operation
- Register map by `dir_i[2:0]`:
  - 0 CTRL: `[0]` EN, `[1]` AUTO (auto-reload), `[2]` IRQEN, `[7:3]` read 0.
  - 1 PRESC: prescaler; one tick every PRESC+1 clocks.
  - 2 RELOAD_LO, 3 RELOAD_HI: 16-bit reload value.
  - 4 COUNT_LO, 5 COUNT_HI: current count, read-only; writes ignored.
  - 6 STATUS: `[0]` EXP, sticky; writing 1 clears it, writing 0 has no effect.
  - 7 reserved: reads 0, writes ignored.
- Start: a CTRL write taking EN from 0 to 1 loads COUNT from RELOAD and clears the prescaler.
- The prescaler counts only while EN=1. Each tick:
  - if COUNT≠0, COUNT decrements;
  - if COUNT=0, EXP sets. With AUTO=1, COUNT reloads from RELOAD. With AUTO=0, EN clears and COUNT stays 0.
- Period is (RELOAD+1)×(PRESC+1) clocks.
- RELOAD writes while running take effect at the next load only.
- A PRESC write clears the prescaler counter.
- Writing EN=0 freezes COUNT and the prescaler. A later 0→1 transition reloads COUNT.
- `irq_o` = EXP & IRQEN, output directly from registers.
- Simultaneous events:
  - an EXP set on a tick wins over a same-cycle write-1-clear;
  - a CTRL write of EN=0 in a tick cycle wins, so the tick is discarded.

## Timing
- Selected = `cyc_i & stb_i & (dir_i[15:12]==SEL)`.
- `ack_o` is registered and set on the edge after Selected when `ack_o`=0. It is high for exactly one cycle.
- If `stb_i` is held, accesses are acknowledged every other cycle.
- A write updates its register on the same edge that raises `ack_o`. Read data is registered on that edge and valid while `ack_o`=1.
- Reset values: CTRL, PRESC, RELOAD, COUNT, STATUS and the prescaler are all 0. `ack_o` is 0 internally, so the pin is high-Z when unselected. `dat_o` is high-Z and `irq_o` is 0.
- Reset asserted mid-count clears all state immediately. No expiry or interrupt is produced after release until reprogrammed.
- The first tick comes PRESC+1 clocks after the CTRL write edge.

## Configuration
- `WB_TIMER_LATCH_EN` defined:
  - a COUNT_LO read captures COUNT[15:8] into a shadow register, and COUNT_HI returns the shadow, giving a coherent 16-bit read;
  - the shadow resets to 0.
- `WB_TIMER_LATCH_EN` undefined: COUNT_HI returns live COUNT[15:8] and no shadow register exists.

## Structure
- Shared package/header holds:
  - register offsets: CTRL=0, PRESC=1, RELOAD_LO=2, RELOAD_HI=3, COUNT_LO=4, COUNT_HI=5, STATUS=6;
  - CTRL bit positions: EN=0, AUTO=1, IRQEN=2;
  - STATUS EXP bit 0.
- One sub-module, `timer_prescaler`. Inputs: clk, reset, enable, clear, 8-bit PRESC. Output: one-cycle `tick`.

## Test plan
- Periodic timer:
  - stimulus: write PRESC=3, RELOAD_LO=4, RELOAD_HI=0, then CTRL=0x07;
  - required: EXP and `irq_o` rise 20 clocks after the CTRL ack and recur every 20 clocks;
  - required: writing STATUS=0x01 drops `irq_o` on the ack edge.
- One-shot:
  - stimulus: CTRL=0x05 with RELOAD=2, PRESC=0;
  - required: EXP sets after 3 clocks, then CTRL reads 0x04 and COUNT reads 0x0000 with no further ticks.
- Collision:
  - stimulus: a STATUS=0x01 write acked on the same edge as an expiry tick;
  - required: EXP reads 1 afterwards.
- Address decode:
  - stimulus: a read at 0x0006 (SEL=0x3);
  - required: `ack_o` and `dat_o` stay high-Z;
  - stimulus: a read at 0x3FFE (alias of STATUS);
  - required: ack after 1 cycle with STATUS data.
- Reset mid-count:
  - stimulus: RELOAD=0x1000 running, reset pulsed low for 5 ns between edges;
  - required: COUNT, CTRL and `irq_o` read 0 immediately and stay 0 after release.
- Latch (macro defined):
  - stimulus: COUNT=0x0100, read COUNT_LO, let a decrement occur, then read COUNT_HI;
  - required: reads return 0x00 then 0x01, not 0x00;
  - required with the macro undefined: COUNT_HI reads 0x00.
